// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM pipeline stage serving byte load/store (one beat) and load pair (two beats) on a data memory port.
// Latency: pass op gives valid_out one cycle after accept; memory ops take one cycle per ack wait plus a final DONE cycle.
// Backpressure: stall_out is high outside IDLE and upstream must hold inputs; MEM_ACCESS_TIMEOUT_EN enables the ack-timeout abort.
module mem_access_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        nreset,
    input  logic        valid_in,
    input  logic [1:0]  op_in,
    input  logic [13:0] addr_in,
    input  logic [7:0]  data_top_in,
    input  logic [7:0]  data_bot_in,
    input  logic [31:0] instruction_in,
    input  logic [1:0]  reg_file_wen_in,
    output logic        stall_out,
    output logic        mem_req,
    output logic        mem_we,
    output logic [13:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        valid_out,
    output logic [7:0]  data_top_out,
    output logic [7:0]  data_bot_out,
    output logic [31:0] instruction_out,
    output logic [1:0]  reg_file_wen_out,
    output logic [13:0] ret_addr_out,
    output logic        err_out
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, DONE} state_t;

    localparam logic [1:0] OP_PASS = 2'b00;
    localparam logic [1:0] OP_LDB  = 2'b01;
    localparam logic [1:0] OP_STB  = 2'b10;
    localparam logic [1:0] OP_LDP  = 2'b11;

    // Everything handed to mem_wb, updated together on entry to DONE.
    typedef struct packed {
        logic [7:0]  top;
        logic [7:0]  bot;
        logic [31:0] instr;
        logic [1:0]  wen;
        logic [13:0] ret;
    } wb_t;

    // Stores never write the register file; the return address is built from the final data bytes.
    function automatic wb_t make_wb(input logic [1:0] op, input logic [7:0] top, input logic [7:0] bot,
                                    input logic [31:0] instr, input logic [1:0] wen);
        wb_t w;
        w.top   = top;
        w.bot   = bot;
        w.instr = instr;
        w.wen   = (op == OP_STB) ? 2'b00 : wen;
        w.ret   = {top[5:0], bot};
        return w;
    endfunction

    state_t      state_q;
    logic [1:0]  op_q;
    logic [13:0] addr_q;
    logic [7:0]  top_q;
    logic [7:0]  bot_q;
    logic [31:0] instr_q;
    logic [1:0]  wen_q;
    wb_t         wb_q;
    logic        valid_q;
    logic        err_q;
    logic        stall_q;
    logic        req_q;
    logic        we_q;
    logic [13:0] maddr_q;
    logic [7:0]  wdata_q;

`ifdef MEM_ACCESS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
`endif

    // Access FSM with registered memory-port, handshake and writeback outputs.
    always_ff @(posedge clock) begin
        if (!nreset) begin
            state_q <= IDLE;
            op_q    <= '0;
            addr_q  <= '0;
            top_q   <= '0;
            bot_q   <= '0;
            instr_q <= '0;
            wen_q   <= '0;
            wb_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            stall_q <= 1'b0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            maddr_q <= '0;
            wdata_q <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (valid_in) begin
                        op_q    <= op_in;
                        addr_q  <= addr_in;
                        top_q   <= data_top_in;
                        bot_q   <= data_bot_in;
                        instr_q <= instruction_in;
                        wen_q   <= reg_file_wen_in;
                        stall_q <= 1'b1;
                        if (op_in == OP_PASS) begin
                            wb_q    <= make_wb(op_in, data_top_in, data_bot_in, instruction_in, reg_file_wen_in);
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            req_q   <= 1'b1;
                            we_q    <= (op_in == OP_STB);
                            maddr_q <= addr_in;
                            wdata_q <= data_bot_in;
                            state_q <= ACC0;
                        end
                    end
                end
                ACC0: begin
                    if (mem_ack) begin
                        if (op_q == OP_LDP) begin
                            // First beat of a pair lands in the top byte; the second address wraps at 14 bits.
                            top_q   <= mem_rdata;
                            maddr_q <= addr_q + 14'd1;
                            state_q <= ACC1;
                        end else begin
                            wb_q    <= make_wb(op_q, top_q, (op_q == OP_LDB) ? mem_rdata : bot_q, instr_q, wen_q);
                            req_q   <= 1'b0;
                            we_q    <= 1'b0;
                            maddr_q <= '0;
                            wdata_q <= '0;
                            valid_q <= 1'b1;
                            state_q <= DONE;
                        end
                    end
                end
                ACC1: begin
                    if (mem_ack) begin
                        wb_q    <= make_wb(op_q, top_q, mem_rdata, instr_q, wen_q);
                        req_q   <= 1'b0;
                        maddr_q <= '0;
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    stall_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
`ifdef MEM_ACCESS_TIMEOUT_EN
            // Wait counter runs only while an access is outstanding without ack; anything else clears it.
            if ((state_q == ACC0 || state_q == ACC1) && !mem_ack) begin
                if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    wb_q    <= make_wb(op_q, 8'hFF, 8'hFF, instr_q, 2'b00);
                    req_q   <= 1'b0;
                    we_q    <= 1'b0;
                    maddr_q <= '0;
                    wdata_q <= '0;
                    valid_q <= 1'b1;
                    err_q   <= 1'b1;
                    cnt_q   <= '0;
                    state_q <= DONE;
                end else begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end else begin
                cnt_q <= '0;
            end
`endif
        end
    end

    assign stall_out        = stall_q;
    assign mem_req          = req_q;
    assign mem_we           = we_q;
    assign mem_addr         = maddr_q;
    assign mem_wdata        = wdata_q;
    assign valid_out        = valid_q;
    assign data_top_out     = wb_q.top;
    assign data_bot_out     = wb_q.bot;
    assign instruction_out  = wb_q.instr;
    assign reg_file_wen_out = wb_q.wen;
    assign ret_addr_out     = wb_q.ret;
    assign err_out          = err_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, max wait cycles for mem_ack before abort (used only with timeout feature).
REQ-002 clock  in  1  system clock, all state on rising edge.
REQ-003 nreset  in  1  synchronous, active-low reset.
REQ-004 valid_in  in  1  ex_mem holds a valid instruction.
REQ-005 op_in  in  2  00 pass, 01 load byte, 10 store byte, 11 load pair.
REQ-006 addr_in  in  14  data memory address.
REQ-007 data_top_in / data_bot_in  in  8 each  operands from ex_mem.
REQ-008 instruction_in  in  32; reg_file_wen_in  in  2  forwarded to mem_wb.
REQ-009 stall_out  out  1  upstream holds all inputs while high.
REQ-010 mem_req, mem_we  out  1 each; mem_addr  out  14; mem_wdata  out  8  data memory port.
REQ-011 mem_rdata  in  8; mem_ack  in  1  memory response, valid only while mem_req is high.
REQ-012 valid_out  out  1; data_top_out, data_bot_out  out  8; instruction_out  out  32; reg_file_wen_out  out  2; ret_addr_out  out  14  to mem_wb.
REQ-013 err_out  out  1  one-cycle access-abort pulse.

Function
REQ-014 FSM states IDLE, ACC0, ACC1, DONE; only IDLE accepts input.
REQ-015 IDLE, valid_in=1, op=00: latch all inputs; -> DONE (one cycle latency to valid_out).
REQ-016 IDLE, valid_in=1, op!=00: latch inputs; -> ACC0; mem_req=1, mem_addr=addr_in, mem_we=(op==10), mem_wdata=data_bot_in (latched).
REQ-017 ACC0 on mem_ack: op 01 -> capture mem_rdata into bot, -> DONE; op 10 -> DONE; op 11 -> capture into top, -> ACC1.
REQ-018 ACC1: mem_addr = latched addr+1 modulo 2^14 (0x3FFF wraps to 0x0000); on mem_ack capture into bot, -> DONE.
REQ-019 mem_req stays high and mem_addr/mem_we/mem_wdata stable in ACC0/ACC1 until mem_ack; mem_req low in IDLE/DONE.
REQ-020 DONE: valid_out=1 for exactly one cycle, -> IDLE; outputs hold value until next DONE.
REQ-021 Non-loaded output byte passes latched operand unchanged (load byte: top=data_top_in).
REQ-022 ret_addr_out = {data_top_out[5:0], data_bot_out} of the same transfer.
REQ-023 stall_out = 1 in ACC0, ACC1, DONE, and in IDLE never.
REQ-024 mem_ack while mem_req=0 is ignored; valid_in=0 in IDLE leaves state and outputs unchanged.
REQ-025 Store reg_file_wen_out forced 00; other ops pass reg_file_wen_in.

Reset
REQ-026 nreset=0 at any edge: state IDLE, every output 0 (including mem_req, stall_out, err_out), latches cleared.
REQ-027 Reset mid-access aborts without valid_out; mem_req low from next edge; later stale mem_ack ignored.

Configuration
REQ-028 Macro MEM_ACCESS_TIMEOUT_EN defined: cycle counter clears on ACC0 entry and on each ack, counts while in ACC0/ACC1 without ack.
REQ-029 Counter reaching TIMEOUT_CYCLES: -> DONE, data_top_out=data_bot_out=0xFF, reg_file_wen_out=00, err_out=1 for that DONE cycle.
REQ-030 Macro undefined: no counter, FSM waits indefinitely for mem_ack, err_out constant 0.

Verification
REQ-031 op=00, data 0x12/0x34, instr 0xDEADBEEF -> next cycle valid_out=1, outputs 0x12/0x34/0xDEADBEEF, no mem_req.
REQ-032 load byte addr 0x0100, ack after 3 wait cycles rdata 0xA5 -> stall 5 cycles, data_bot_out=0xA5, top passes through.
REQ-033 load pair addr 0x3FFF, rdata 0x3C then 0x21 -> second mem_addr 0x0000, ret_addr_out=0x3C21.
REQ-034 store 0x77 at 0x0042 -> mem_we=1, mem_wdata=0x77, reg_file_wen_out=00.
REQ-035 nreset low during ACC1 of load pair -> no valid_out, all outputs 0, mem_req low next edge.
REQ-036 MEM_ACCESS_TIMEOUT_EN, TIMEOUT_CYCLES=4, no ack -> err_out pulse, data 0xFF/0xFF, state IDLE after.
